// File: rtl/ldpc_qc_enc_if.sv
// Streaming bus for the QC-LDPC encoder: message blocks in, codeword blocks out.
// The master drives messages and out_ready; the slave (the encoder) drives the rest.
interface ldpc_qc_enc_if #(
    parameter int D = 24
);
    logic [D-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/ldpc_qc_enc.sv
// Systematic QC-LDPC encoder: message blocks pass straight through while parity is accumulated.
// Optional feature: define LDPC_ENC_CWCNT_EN to add the cw_cnt codeword counter output.
module ldpc_qc_enc #(
    parameter int data_w = 8,
    parameter int KB     = 12,
    parameter int PB     = 12,
    parameter int D      = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [KB*PB*data_w-1:0]  gmtx,
    ldpc_qc_enc_if.slave             io
`ifdef LDPC_ENC_CWCNT_EN
    ,
    output logic [15:0]              cw_cnt
`endif
);

    localparam int MAXB = (KB > PB) ? KB : PB;
    localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;

    localparam logic [0:0] ACC = 1'b0;
    localparam logic [0:0] PAR = 1'b1;

    localparam logic [BW-1:0] KB_LAST = BW'(KB - 1);
    localparam logic [BW-1:0] PB_LAST = BW'(PB - 1);

    logic [0:0]      state;
    logic [BW-1:0]   blk;
    logic [PB*D-1:0] par_q;
    logic [PB*D-1:0] par_nxt;
    logic            active;
    logic            in_fire;
    logic            out_fire;

    // Cyclic right rotation by s; any shift of D or more is the null circulant.
    function automatic logic [D-1:0] rot(input logic [D-1:0] m, input logic [data_w-1:0] s);
        logic [2*D-1:0] sh;
        sh = {m, m} >> s;
        return (32'(s) < D) ? sh[D-1:0] : '0;
    endfunction

    assign active   = en & rst;
    assign in_fire  = active && (state == ACC) && io.in_valid && io.out_ready;
    assign out_fire = active && (state == PAR) && io.out_ready;

    // NOTE: every output gets a default before the branches, otherwise synthesis infers latches.
    always_comb begin
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        io.out_data  = '0;
        io.out_last  = 1'b0;
        if (active) begin
            if (state == ACC) begin
                io.out_data  = io.in_data;
                io.out_valid = io.in_valid;
                io.in_ready  = io.out_ready;
            end else begin
                io.out_valid = 1'b1;
                io.out_data  = par_q[int'(blk)*D +: D];
                io.out_last  = (blk == PB_LAST);
            end
        end
    end

    // Block 0 of a codeword overwrites the accumulators, so no explicit clear pass is needed.
    always_comb begin
        par_nxt = par_q;
        for (int c = 0; c < PB; c++) begin
            par_nxt[c*D +: D] = ((blk == '0) ? '0 : par_q[c*D +: D])
                              ^ rot(io.in_data, gmtx[(int'(blk)*PB + c)*data_w +: data_w]);
        end
    end

    // NOTE: par is a bank of flops rather than a RAM, so it takes the async clear like any register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACC;
            blk   <= '0;
            par_q <= '0;
        end else if (in_fire) begin
            par_q <= par_nxt;
            if (blk == KB_LAST) begin
                state <= PAR;
                blk   <= '0;
            end else begin
                blk <= blk + BW'(1);
            end
        end else if (out_fire) begin
            if (blk == PB_LAST) begin
                state <= ACC;
                blk   <= '0;
            end else begin
                blk <= blk + BW'(1);
            end
        end
    end

`ifdef LDPC_ENC_CWCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cw_cnt <= '0;
        end else if (out_fire && io.out_last) begin
            cw_cnt <= cw_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/ldpc_qc_enc.md
LDPC_QC_ENC -- requirements
Module: ldpc_qc_enc

Interface
REQ-001 Parameter data_w, default 8: width of one circulant shift entry.
REQ-002 Parameter KB, default 12: message (systematic) blocks per codeword.
REQ-003 Parameter PB, default 12: parity blocks per codeword.
REQ-004 Parameter D, default 24: circulant size, bits per block.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  global enable; when low, in_ready=0, out_valid=0 and no state changes.
REQ-008 gmtx  input  KB*PB*data_w  generator shift table; entry (j,c) at bits [(j*PB+c)*data_w +: data_w]; static during a codeword.
REQ-009 in_data  input  D  message block.
REQ-010 in_valid  input  1  in_data valid.
REQ-011 in_ready  output  1  block accepted when in_valid & in_ready ("in fire").
REQ-012 out_data  output  D  codeword block.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  block taken when out_valid & out_ready ("out fire").
REQ-015 out_last  output  1  high with the final parity block of a codeword.

Function
REQ-016 FSM states: ACC (message pass-through, parity accumulation) and PAR (parity emission); block counter blk, 0..max(KB,PB)-1.
REQ-017 ACC, en=1: out_data=in_data, out_valid=in_valid, in_ready=out_ready, out_last=0, all combinational (zero latency).
REQ-018 Rotation: rot(m,s)[k] = m[(k+s) mod D]; s >= D, including all-ones, means null circulant (contributes zero).
REQ-019 In fire in ACC at blk=0: par[c] <= rot(in_data, gmtx(0,c)) for all c (implicit clear); at blk>0: par[c] <= par[c] ^ rot(in_data, gmtx(blk,c)).
REQ-020 In fire with blk=KB-1: state -> PAR, blk -> 0; otherwise blk increments.
REQ-021 PAR, en=1: in_ready=0, out_valid=1, out_data=par[blk], out_last=(blk==PB-1).
REQ-022 Out fire in PAR: blk increments; at blk=PB-1, state -> ACC, blk -> 0.
REQ-023 First parity block is valid the cycle after the last message in fire; no bubble between codewords.
REQ-024 out_data is held stable while out_valid=1 and out_ready=0.
REQ-025 en deasserted mid-codeword freezes state, blk and par; resumes exactly where it stopped.

Reset
REQ-026 rst=0 asynchronously forces state=ACC, blk=0, every par[c]=0, out_last=0; out_valid=0 and in_ready=0 while rst=0.
REQ-027 Reset mid-codeword discards the partial codeword; the next accepted block is block 0.

Configuration
REQ-028 With macro LDPC_ENC_CWCNT_EN defined: output cw_cnt [15:0] is reset to 0 and increments on every out fire with out_last=1, wrapping 16'hFFFF -> 0.
REQ-029 Without LDPC_ENC_CWCNT_EN: cw_cnt port and counter are absent; all other behaviour is identical.

Verification
REQ-030 Defaults, all gmtx entries 0, message block j = 24'h1<<j, out_ready=1 -> 12 pass-through blocks, then 12 parity blocks, each 24'h000FFF; out_last only on the 24th output.
REQ-031 All gmtx entries 8'hFF, random message -> all 12 parity blocks 24'h000000.
REQ-032 Block 0 = 24'h000001, others 0, gmtx(0,c)=c -> parity c has only bit (24-c) mod 24 set (c=0: bit 0; c=1: bit 23).
REQ-033 out_ready low for 3 cycles at parity block 5 -> out_data/out_valid stable, no block skipped or repeated; in_ready low throughout PAR.
REQ-034 rst pulsed low after 5 message fires, then full REQ-030 codeword -> outputs match REQ-030 exactly.
REQ-035 LDPC_ENC_CWCNT_EN defined, 3 back-to-back codewords -> cw_cnt steps 0 -> 1 -> 2 -> 3, each step the cycle after the out_last fire.
